// File: rtl/pleiads_rom_loader.sv
// HPS download steering for the Pleiads core: routes download bytes into the
// program, character and palette ROM regions and holds the core in reset until the load settles.
module pleiads_rom_loader #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        cpu_rom_we,
  output logic        bg_rom_we,
  output logic        fg_rom_we,
  output logic        prom_we,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        core_reset,
  output logic        dl_done,
  output logic        dl_error,
  output logic [7:0]  checksum,
  output logic [16:0] byte_count
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
  typedef enum logic [1:0] {SEL_CPU, SEL_BG, SEL_FG, SEL_PROM} sel_t;

  state_t      state;
  logic [7:0]  hold_cnt;

  logic        window_p0;
  logic        entering_p0;
  logic        vld_p0;
  logic        bad_p0;
  sel_t        sel_p0;
  logic [15:0] addr_p0;

  function automatic logic [16:0] sat_inc(input logic [16:0] v);
    return (v == 17'h1FFFF) ? v : v + 17'd1;
  endfunction

  // Stage p0: window, region decode and local address of the incoming byte
  always_comb begin
    window_p0   = (state == LOAD) || dl_active;
    entering_p0 = dl_active && (state != LOAD);
    vld_p0      = 1'b0;
    bad_p0      = 1'b0;
    sel_p0      = SEL_CPU;
    addr_p0     = 16'h0000;
    if (dl_addr < 25'h04000) begin
      sel_p0  = SEL_CPU;
      addr_p0 = {2'b00, dl_addr[13:0]};
    end else if (dl_addr < 25'h05000) begin
      sel_p0  = SEL_BG;
      addr_p0 = {4'h0, dl_addr[11:0]};
    end else if (dl_addr < 25'h06000) begin
      sel_p0  = SEL_FG;
      addr_p0 = {4'h0, dl_addr[11:0]};
    end else begin
      sel_p0  = SEL_PROM;
      addr_p0 = {7'h00, dl_addr[8:0]};
    end
    if (window_p0 && dl_wr) begin
      vld_p0 = (dl_addr < 25'h06200);
      bad_p0 = !vld_p0;
    end
  end

  // Stage p1: registered strobes, bookkeeping and control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold_cnt   <= 8'h00;
      cpu_rom_we <= 1'b0;
      bg_rom_we  <= 1'b0;
      fg_rom_we  <= 1'b0;
      prom_we    <= 1'b0;
      wr_addr    <= 16'h0000;
      wr_data    <= 8'h00;
      core_reset <= 1'b1;
      dl_done    <= 1'b0;
      dl_error   <= 1'b0;
      checksum   <= 8'h00;
      byte_count <= 17'h00000;
    end else begin
      cpu_rom_we <= vld_p0 && (sel_p0 == SEL_CPU);
      bg_rom_we  <= vld_p0 && (sel_p0 == SEL_BG);
      fg_rom_we  <= vld_p0 && (sel_p0 == SEL_FG);
      prom_we    <= vld_p0 && (sel_p0 == SEL_PROM);
      dl_done    <= 1'b0;
      if (vld_p0) begin
        wr_addr <= addr_p0;
        wr_data <= dl_data;
      end

      // A byte landing on the entry edge becomes the first byte of the fresh download
      if (entering_p0) begin
        byte_count <= vld_p0 ? 17'd1 : 17'd0;
        checksum   <= vld_p0 ? dl_data : 8'h00;
        dl_error   <= bad_p0;
      end else begin
        if (vld_p0) begin
          byte_count <= sat_inc(byte_count);
          checksum   <= checksum + dl_data;
        end
        if (bad_p0) dl_error <= 1'b1;
      end

      case (state)
        IDLE: if (dl_active) state <= LOAD;
        LOAD: begin
          if (!dl_active) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (dl_active) begin
            state    <= LOAD;
            hold_cnt <= 8'h00;
          end else if (hold_cnt <= 8'd1) begin
            state      <= RUN;
            hold_cnt   <= 8'h00;
            dl_done    <= 1'b1;
            core_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        RUN: begin
          if (dl_active) begin
            state      <= LOAD;
            core_reset <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
